add_sub_arbiter: RTL and testbench
==================================

# add_sub_arbiter

Round-robin arbiter and sequencer sharing one `add_sub_cla` 16-bit scaled add/subtract unit between `NUM_REQ` solver requesters. Requesters post operands with a request/grant handshake. The block registers the winning operands, drives the shared adder for one cycle, captures result, carry and invalid flag, and returns them to the winner with a one-cycle response strobe. It sits between the ODE-solver stage controllers and the single adder instance.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req`  in  NUM_REQ: per-requester request level.
- `req_sub`  in  NUM_REQ: per-requester op select. 1 = in1−in2, 0 = in1+in2.
- `req_in1`  in  16*NUM_REQ: flattened operand 1. Requester i uses bits [16i+15:16i].
- `req_in2`  in  16*NUM_REQ: flattened operand 2, same packing.
- `gnt`  out  NUM_REQ: one-hot, one-cycle grant pulse.
- `rsp_valid`  out  NUM_REQ: one-hot, one-cycle response strobe to the owner.
- `rsp_out`  out  16: result. [15:13] scale, [12:0] mantissa.
- `rsp_cout`  out  1: adder carry out.
- `rsp_invalid`  out  1: adder overflow/invalid flag.
- `busy`  out  1: high whenever state ≠ IDLE.
- `ovf_count`  out  16: invalid-result counter (see Configuration).

## Operation
- FSM states: IDLE, OP, DONE.
- IDLE:
  - If any `req` bit is set, pick a winner by round-robin from pointer `ptr`. Search order is ptr, ptr+1, …, wrapping mod NUM_REQ.
  - Pulse `gnt[w]`. Latch the winner's `in1`, `in2`, `sub` and index into operand registers. Go to OP.
  - If no request, stay in IDLE.
- OP:
  - Adder driven from operand registers with `enable=1`, `cin=0`; adder `reset` tied to `reset`.
  - At the end of the cycle, register adder `out`, `cout` and `invalid` into `rsp_*`. Go to DONE.
- DONE:
  - Pulse `rsp_valid[owner]`. Set `ptr = owner+1` (mod NUM_REQ). Go to IDLE.
- `rsp_out`, `rsp_cout` and `rsp_invalid` hold their value until the next capture.
- Requesters must hold `req` and operands stable until they see `gnt`. Operands may change the cycle after `gnt`.
- A requester may keep `req` high for back-to-back ops. It is re-arbitrated fairly against the others.
- A `req` dropped before grant is simply not served; there is no error.
- `req` changes while `busy` are ignored until IDLE.
- Arithmetic is the adder's rule:
  - Result scale = max(scale1, scale2).
  - The smaller-scale mantissa is shifted left by the scale difference.
  - Mantissas are sign-extended from bit 12 to 20 bits.
  - Invalid when the 20-bit sum bits [19:12] are not all-0 or all-1, or on internal adder overflow.

## Timing
- Reset values:
  - state IDLE, `ptr`=0.
  - `gnt`=0, `rsp_valid`=0, `rsp_out`=0, `rsp_cout`=0, `rsp_invalid`=0.
  - `busy`=0, `ovf_count`=0, operand registers 0.
- Latency: `gnt` in cycle N, result registered at the end of N+1, `rsp_valid` in cycle N+2.
- Throughput: one op per 3 cycles under continuous load.
- Requests present at N+2 are granted at N+3.
- Simultaneous requests: exactly one grant, decided by `ptr`. No requester waits more than NUM_REQ−1 ops.
- Reset mid-operation (OP or DONE): transaction dropped, no `rsp_valid`, next cycle all outputs at reset values.
- `gnt` and `rsp_valid` are never high in the same cycle.

## Configuration
- `ADDSUB_ARB_OVF_CNT_EN` defined:
  - `ovf_count` increments in DONE when `rsp_invalid`=1.
  - Saturates at 16'hFFFF. Cleared by `reset`.
- Not defined: `ovf_count` is tied to 0 and no counter logic is built.

## Structure
- Shared package `add_sub_arb_pkg` holds:
  - the state encoding (IDLE=2'd0, OP=2'd1, DONE=2'd2);
  - the word-format constants SCALE_MSB=15, SCALE_LSB=13, MANT_MSB=12;
  - the flattened-operand width WORD_W=16.
- Sub-module `rr_pick`: combinational round-robin picker, (`req`, `ptr`) → one-hot winner plus index.
- One `add_sub_cla` instance inside the block.

## Test plan
- Single add: req[0], in1=16'h0005, in2=16'h0003, sub=0 → `gnt[0]` at N, `rsp_valid[0]` at N+2, `rsp_out`=16'h0008, `rsp_invalid`=0.
- Subtract: req[2], in1=16'h000A, in2=16'h0003, sub=1 → `rsp_out`=16'h0007, `rsp_valid[2]` only.
- Scale alignment: in1=16'h2001, in2=16'h0001, add → `rsp_out`=16'h2003.
- Overflow: in1=16'h0FFF, in2=16'h0001, add → `rsp_invalid`=1; with `ADDSUB_ARB_OVF_CNT_EN`, `ovf_count`=1.
- Fairness: all four `req` held high for 8 ops from reset → grant order 0,1,2,3,0,1,2,3, one `gnt` every 3 cycles.
- Reset in OP: assert `reset` the cycle after `gnt[1]` → no `rsp_valid`, all outputs 0, `ptr`=0, and a subsequent req[1] is granted normally.

Source files
------------

// File: rtl/add_sub_arbiter_pkg.sv
// Shared types and word-format constants for the add/sub arbiter slice.
// FSM encoding, 16-bit scaled-word layout and operand width.
package add_sub_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int SCALE_MSB = 15;
    localparam int SCALE_LSB = 13;
    localparam int MANT_MSB  = 12;
    localparam int WORD_W    = 16;
    localparam int EXT_W     = 20;

    // Sign-extend a 13-bit mantissa to the adder's internal width
    function automatic logic [EXT_W-1:0] sext_mant(input logic [MANT_MSB:0] m);
        return {{(EXT_W-MANT_MSB-1){m[MANT_MSB]}}, m};
    endfunction

endpackage

// File: rtl/add_sub_arbiter_if.sv
// Request/grant and response bundle between solver requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface add_sub_arbiter_if
    import add_sub_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_sub;
    logic [WORD_W*NUM_REQ-1:0] req_in1;
    logic [WORD_W*NUM_REQ-1:0] req_in2;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [WORD_W-1:0]         rsp_out;
    logic                      rsp_cout;
    logic                      rsp_invalid;
    logic                      busy;
    logic [15:0]               ovf_count;

    modport master (
        output req, req_sub, req_in1, req_in2,
        input  gnt, rsp_valid, rsp_out, rsp_cout, rsp_invalid, busy, ovf_count
    );

    modport slave (
        input  req, req_sub, req_in1, req_in2,
        output gnt, rsp_valid, rsp_out, rsp_cout, rsp_invalid, busy, ovf_count
    );
endinterface

// File: rtl/add_sub_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot winner, its index and an any-request flag.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [PW-1:0] idx,
    output logic          any
);
    int j;

    always_comb begin
        win = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any    = 1'b1;
                win[j] = 1'b1;
                idx    = PW'(j);
            end
        end
    end
endmodule

// File: rtl/add_sub_cla.sv
// Combinational 16-bit scaled add/subtract unit ([15:13] scale, [12:0] mantissa).
// Aligns to the larger scale, works in 20 bits and flags unrepresentable results.
module add_sub_cla
    import add_sub_arb_pkg::*;
(
    input  logic              reset,
    input  logic              enable,
    input  logic              cin,
    input  logic              sub,
    input  logic [WORD_W-1:0] in1,
    input  logic [WORD_W-1:0] in2,
    output logic [WORD_W-1:0] out,
    output logic              cout,
    output logic              invalid
);
    logic [2:0]       sc1, sc2, sc_max, sh1, sh2;
    logic [EXT_W-1:0] m1, m2, b_eff, sum;
    logic [EXT_W:0]   sum_c;
    logic [EXT_W-1-MANT_MSB:0] hi;
    logic             ovf;

    always_comb begin
        sc1    = in1[SCALE_MSB:SCALE_LSB];
        sc2    = in2[SCALE_MSB:SCALE_LSB];
        sc_max = (sc1 > sc2) ? sc1 : sc2;
        sh1    = sc_max - sc1;
        sh2    = sc_max - sc2;
        m1     = sext_mant(in1[MANT_MSB:0]) << sh1;
        m2     = sext_mant(in2[MANT_MSB:0]) << sh2;
        b_eff  = sub ? ~m2 : m2;
        // sub ^ cin supplies the two's-complement +1 when subtracting
        sum_c  = {1'b0, m1} + {1'b0, b_eff} + {{EXT_W{1'b0}}, sub ^ cin};
        sum    = sum_c[EXT_W-1:0];
        ovf    = (m1[EXT_W-1] == b_eff[EXT_W-1]) && (sum[EXT_W-1] != m1[EXT_W-1]);
        hi     = sum[EXT_W-1:MANT_MSB];
        out     = '0;
        cout    = 1'b0;
        invalid = 1'b0;
        if (!reset && enable) begin
            out     = {sc_max, sum[MANT_MSB:0]};
            cout    = sum_c[EXT_W];
            invalid = !((hi == '0) || (hi == '1)) || ovf;
        end
    end
endmodule

// File: rtl/add_sub_arbiter.sv
// Round-robin arbiter sharing one add_sub_cla between NUM_REQ requesters.
// Define ADDSUB_ARB_OVF_CNT_EN to build the saturating invalid-result counter.
module add_sub_arbiter
    import add_sub_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic               clk,
    input logic               reset,
    add_sub_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NUM_REQ);

    state_e            state_q;
    logic [PW-1:0]     ptr_q, ptr_d, owner_q;
    logic [WORD_W-1:0] in1_q, in2_q, out_q;
    logic              sub_q, cout_q, inv_q;
    logic [NUM_REQ-1:0] vld_q;

    logic [NUM_REQ-1:0] win;
    logic [PW-1:0]      win_idx;
    logic               any;
    logic [WORD_W-1:0]  add_out;
    logic               add_cout, add_inv;

    rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req (bus.req),
        .ptr (ptr_q),
        .win (win),
        .idx (win_idx),
        .any (any)
    );

    add_sub_cla u_cla (
        .reset   (reset),
        .enable  (1'b1),
        .cin     (1'b0),
        .sub     (sub_q),
        .in1     (in1_q),
        .in2     (in2_q),
        .out     (add_out),
        .cout    (add_cout),
        .invalid (add_inv)
    );

    assign ptr_d = (owner_q == PW'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            sub_q   <= 1'b0;
            out_q   <= '0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
            vld_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    vld_q <= '0;
                    if (any) begin
                        in1_q   <= bus.req_in1[int'(win_idx)*WORD_W +: WORD_W];
                        in2_q   <= bus.req_in2[int'(win_idx)*WORD_W +: WORD_W];
                        sub_q   <= bus.req_sub[win_idx];
                        owner_q <= win_idx;
                        state_q <= OP;
                    end
                end
                OP: begin
                    out_q   <= add_out;
                    cout_q  <= add_cout;
                    inv_q   <= add_inv;
                    vld_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
                    state_q <= DONE;
                end
                DONE: begin
                    vld_q   <= '0;
                    ptr_q   <= ptr_d;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is decoded in IDLE so operands latch in the same cycle gnt is seen
    assign bus.gnt         = (state_q == IDLE && !reset) ? win : '0;
    assign bus.rsp_valid   = reset ? '0 : vld_q;
    assign bus.rsp_out     = out_q;
    assign bus.rsp_cout    = cout_q;
    assign bus.rsp_invalid = inv_q;
    assign bus.busy        = (state_q != IDLE);

`ifdef ADDSUB_ARB_OVF_CNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= '0;
        end else if (state_q == DONE && inv_q && ovf_q != 16'hFFFF) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign bus.ovf_count = ovf_q;
`else
    assign bus.ovf_count = '0;
`endif
endmodule

// File: tb/tb_add_sub_arbiter.sv
// Directed bench for add_sub_arbiter: single ops, scale, overflow, fairness, reset.
// Inputs driven 1ns after posedge; outputs checked in the same phase.
module tb_add_sub_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    add_sub_arbiter_if #(.NUM_REQ(4)) bus ();

    add_sub_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef ADDSUB_ARB_OVF_CNT_EN
    localparam logic [15:0] OVF_EXP = 16'd1;
`else
    localparam logic [15:0] OVF_EXP = 16'd0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [15:0] a, input logic [15:0] b,
                            input logic s);
        bus.req_in1[i*16 +: 16] = a;
        bus.req_in2[i*16 +: 16] = b;
        bus.req_sub[i]          = s;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        bus.req = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic do_op(input string tag, input int i, input logic [15:0] a,
                         input logic [15:0] b, input logic s, input logic [15:0] eo,
                         input logic ec, input logic ei);
        logic [31:0] oh;
        oh = 32'd1 << i;
        set_slot(i, a, b, s);
        bus.req    = '0;
        bus.req[i] = 1'b1;
        #1;
        chk({tag, ".gnt"}, 32'(bus.gnt), oh);
        step();
        bus.req = '0;
        chk({tag, ".busy"}, 32'(bus.busy), 32'd1);
        chk({tag, ".gnt_op"}, 32'(bus.gnt), 32'd0);
        chk({tag, ".vld_op"}, 32'(bus.rsp_valid), 32'd0);
        step();
        chk({tag, ".vld"}, 32'(bus.rsp_valid), oh);
        chk({tag, ".out"}, 32'(bus.rsp_out), 32'(eo));
        chk({tag, ".cout"}, 32'(bus.rsp_cout), 32'(ec));
        chk({tag, ".inv"}, 32'(bus.rsp_invalid), 32'(ei));
        chk({tag, ".gnt_done"}, 32'(bus.gnt), 32'd0);
        step();
        chk({tag, ".vld_idle"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, ".hold"}, 32'(bus.rsp_out), 32'(eo));
        chk({tag, ".idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req     = '0;
        bus.req_sub = '0;
        bus.req_in1 = '0;
        bus.req_in2 = '0;
        do_reset();

        chk("rst.gnt", 32'(bus.gnt), 32'd0);
        chk("rst.vld", 32'(bus.rsp_valid), 32'd0);
        chk("rst.out", 32'(bus.rsp_out), 32'd0);
        chk("rst.cout", 32'(bus.rsp_cout), 32'd0);
        chk("rst.inv", 32'(bus.rsp_invalid), 32'd0);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.ovf", 32'(bus.ovf_count), 32'd0);

        do_op("add0", 0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
        do_op("sub2", 2, 16'h000A, 16'h0003, 1'b1, 16'h0007, 1'b1, 1'b0);
        do_op("neg3", 3, 16'h0003, 16'h000A, 1'b1, 16'h1FF9, 1'b0, 1'b0);
        do_op("scale1", 1, 16'h2001, 16'h0001, 1'b0, 16'h2003, 1'b0, 1'b0);
        chk("pre_ovf", 32'(bus.ovf_count), 32'd0);
        do_op("ovf3", 3, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b1);
        chk("ovf_cnt", 32'(bus.ovf_count), 32'(OVF_EXP));

        // Fairness: all four requesting continuously from reset
        do_reset();
        for (int i = 0; i < 4; i++) set_slot(i, 16'(i + 1), 16'h0001, 1'b0);
        bus.req = 4'hF;
        #1;
        for (int k = 0; k < 8; k++) begin
            chk("fair.gnt", 32'(bus.gnt), 32'd1 << (k % 4));
            step();
            chk("fair.gap1", 32'(bus.gnt), 32'd0);
            step();
            chk("fair.gap2", 32'(bus.gnt), 32'd0);
            chk("fair.vld", 32'(bus.rsp_valid), 32'd1 << (k % 4));
            chk("fair.out", 32'(bus.rsp_out), 32'((k % 4) + 2));
            step();
        end
        bus.req = '0;
        step();
        step();

        // Reset while in OP: move ptr off 0 first
        do_op("pre2", 2, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        set_slot(1, 16'h0004, 16'h0002, 1'b0);
        bus.req = 4'b0010;
        #1;
        chk("rop.gnt", 32'(bus.gnt), 32'd2);
        step();
        bus.req = '0;
        reset   = 1'b1;
        step();
        reset = 1'b0;
        chk("rop.busy", 32'(bus.busy), 32'd0);
        chk("rop.vld", 32'(bus.rsp_valid), 32'd0);
        chk("rop.out", 32'(bus.rsp_out), 32'd0);
        chk("rop.gnt0", 32'(bus.gnt), 32'd0);
        chk("rop.ovf", 32'(bus.ovf_count), 32'd0);
        step();
        chk("rop.vld2", 32'(bus.rsp_valid), 32'd0);
        step();
        chk("rop.vld3", 32'(bus.rsp_valid), 32'd0);
        // ptr back at 0 means requester 1 beats requester 3
        set_slot(3, 16'h0001, 16'h0001, 1'b0);
        bus.req = 4'b1010;
        #1;
        chk("rop.ptr", 32'(bus.gnt), 32'd2);
        bus.req = '0;
        do_op("post1", 1, 16'h0004, 16'h0002, 1'b0, 16'h0006, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
